// File: rtl/regfile_pkg.sv
// Shared definitions for the register file access controller: default widths,
// command opcodes and the controller state encoding.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 1 << DEF_ADDR_W;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RD_CAP   = 2'b01,
    ST_RSP_WAIT = 2'b10,
    ST_CLEAR    = 2'b11
  } state_e;

endpackage : regfile_pkg

// File: rtl/regfile_access_ctrl.sv
// Command-driven master for the dual-read register file: issues writes, paired
// reads with a registered response channel, and a sequential whole-file clear.
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic              busy,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_rd_addr_a,
  output logic [ADDR_W-1:0] rf_rd_addr_b,
  input  logic [DATA_W-1:0] rf_rd_data_a,
  input  logic [DATA_W-1:0] rf_rd_data_b
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_a_q, rsp_data_a_d;
  logic [DATA_W-1:0] rsp_data_b_q, rsp_data_b_d;
  logic              busy_q, busy_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      rf_write_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      rd_addr_a_q  <= '0;
      rd_addr_b_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_a_q <= '0;
      rsp_data_b_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      rf_write_q   <= rf_write_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      rd_addr_a_q  <= rd_addr_a_d;
      rd_addr_b_q  <= rd_addr_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_a_q <= rsp_data_a_d;
      rsp_data_b_q <= rsp_data_b_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and next-output logic; rf_write is a one-cycle strobe by default
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    rf_write_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    rd_addr_a_d  = rd_addr_a_q;
    rd_addr_b_d  = rd_addr_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_a_d = rsp_data_a_q;
    rsp_data_b_d = rsp_data_b_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE: begin
              rf_write_d   = 1'b1;
              rf_wr_addr_d = cmd_addr_a;
              rf_wr_data_d = cmd_data;
            end
            OP_READ: begin
              rd_addr_a_d = cmd_addr_a;
              rd_addr_b_d = cmd_addr_b;
              state_d     = ST_RD_CAP;
            end
            OP_CLEAR: begin
              rf_write_d   = 1'b1;
              rf_wr_addr_d = '0;
              rf_wr_data_d = '0;
              clr_cnt_d    = '0;
              state_d      = ST_CLEAR;
            end
            default: ;
          endcase
        end
      end
      ST_RD_CAP: begin
        // Hold off the capture while a write is still being presented
        if (!rf_write_q) begin
          rsp_data_a_d = rf_rd_data_a;
          rsp_data_b_d = rf_rd_data_b;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RSP_WAIT;
        end
      end
      ST_RSP_WAIT: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        rf_wr_data_d = '0;
        clr_cnt_d    = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          rf_write_d   = 1'b1;
          rf_wr_addr_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data_a   = rsp_data_a_q;
  assign rsp_data_b   = rsp_data_b_q;
  assign busy         = busy_q;
  assign rf_write     = rf_write_q;
  assign rf_wr_addr   = rf_wr_addr_q;
  assign rf_wr_data   = rf_wr_data_q;
  assign rf_rd_addr_a = rd_addr_a_q;
  assign rf_rd_addr_b = rd_addr_b_q;

endmodule : regfile_access_ctrl
